// File: rtl/ps2_rx_io.sv
// PS/2 keyboard receiver on the processor data bus.
// Deserialises device frames, queues good bytes, exposes DATA/STATUS.
module ps2_rx_io #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0010,
  parameter int          FIFO_DEPTH = 8,
  parameter int          FIFO_AW    = 3,
  parameter int          TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IO_DataAddr,
  input  logic [31:0] PROC_DataOut,
  input  logic [3:0]  bwe,
  output logic [31:0] IO_DataOut,
  output logic        IO_EnableN,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT
);

  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'd4;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t r_state, w_next;

  logic r_clk_s1, r_clk_s2, r_clk_d;
  logic r_dat_s1, r_dat_s2;
  logic w_fall, w_bit;

  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_par;
  logic [WW-1:0] r_wdog;
  logic          w_tmo;

  logic w_start, w_shift, w_plat, w_stop_ev;
  logic w_par_ok, w_push, w_perr_ev, w_ferr_ev, w_cnt_ev;

  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [FIFO_AW:0]   r_cnt;
  logic               w_full, w_empty, w_pop, w_push_ok;

  logic       r_ovf, r_perr, r_ferr;
  logic [7:0] r_err_cnt;

  logic w_wr, w_hit0, w_hit1, w_clr;
  logic r_rd0, r_rd1;
  logic w_unused;

  assign w_unused = ^PROC_DataOut;

  // Two-flop synchronisers plus clock history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_clk_d  <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_clk_d  <= r_clk_s2;
      r_dat_s1 <= PS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_d & ~r_clk_s2;
  assign w_bit  = r_dat_s2;
  assign w_tmo  = (r_state != S_IDLE) & ~w_fall & (r_wdog == WD_LAST);

  // Rx FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Rx FSM next-state logic; watchdog overrides everything
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_fall && !w_bit) w_next = S_DATA;
      S_DATA: if (w_fall && r_bit_cnt == 3'd7) w_next = S_PAR;
      S_PAR:  if (w_fall) w_next = S_PAR == S_PAR ? S_STOP : S_PAR;
      S_STOP: if (w_fall) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_tmo) w_next = S_IDLE;
  end

  // Rx FSM outputs: datapath strobes and frame verdict
  always_comb begin
    w_start   = (r_state == S_IDLE) & w_fall & ~w_bit;
    w_shift   = (r_state == S_DATA) & w_fall;
    w_plat    = (r_state == S_PAR)  & w_fall;
    w_stop_ev = (r_state == S_STOP) & w_fall;
    w_par_ok  = ^{r_shift, r_par};
    w_push    = w_stop_ev & w_bit & w_par_ok;
    w_perr_ev = w_stop_ev & ~w_par_ok;
    w_ferr_ev = (w_stop_ev & ~w_bit) | w_tmo;
    w_cnt_ev  = w_stop_ev & ~(w_bit & w_par_ok);
  end

  // Shift register, bit counter, parity latch and watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_wdog    <= '0;
    end else begin
      if (w_start) r_bit_cnt <= '0;
      if (w_shift) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_plat) r_par <= w_bit;
      if (r_state == S_IDLE || w_fall || w_tmo) r_wdog <= '0;
      else r_wdog <= r_wdog + WW'(1);
    end
  end

  assign w_wr    = |bwe;
  assign w_hit0  = (IO_DataAddr == BASE_ADDR);
  assign w_hit1  = (IO_DataAddr == STAT_ADDR);
  assign w_clr   = w_hit1 & w_wr;
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == FULL_CNT);
  assign w_pop   = w_hit0 & w_wr & ~w_empty;
  assign w_push_ok = w_push & (~w_full | w_pop);

  // FIFO storage; emptied by pointer reset only
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= r_shift;
  end

  // FIFO pointers and occupancy; pop is applied before push
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop)     r_rp <= r_rp + 1'b1;
      if (w_push_ok && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push_ok && w_pop) r_cnt <= r_cnt - 1'b1;
    end
  end

  // Sticky error flags and saturating error count; clear wins
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_ovf     <= 1'b0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_perr_ev) r_perr <= 1'b1;
      if (w_ferr_ev) r_ferr <= 1'b1;
      if (w_cnt_ev && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Remember which register was addressed for the next-cycle read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd0 <= 1'b0;
      r_rd1 <= 1'b0;
    end else begin
      r_rd0 <= w_hit0;
      r_rd1 <= w_hit1;
    end
  end

  // Read mux built from post-update state
  always_comb begin
    IO_EnableN = ~(r_rd0 | r_rd1);
    IO_DataOut = '0;
    if (r_rd0) begin
      IO_DataOut = {23'b0, ~w_empty,
                    w_empty ? 8'h00 : r_mem[r_rp]};
    end else if (r_rd1) begin
      IO_DataOut = {8'b0, r_err_cnt, 5'b0, r_ovf, r_perr,
                    r_ferr, w_full, 7'(r_cnt)};
    end
  end

endmodule

// File: tb/tb_ps2_rx_io.sv
// Randomised self-checking bench for ps2_rx_io.
// Frame-level queue model predicts DATA and STATUS reads.
module tb_ps2_rx_io;

  localparam logic [31:0] BASE = 32'hFFFF_0010;
  localparam logic [31:0] STAT = 32'hFFFF_0014;
  localparam int H = 6;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] IO_DataAddr;
  logic [31:0] PROC_DataOut;
  logic [3:0]  bwe;
  logic [31:0] IO_DataOut;
  logic        IO_EnableN;
  logic        PS2_CLK;
  logic        PS2_DAT;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_q[$];
  bit         m_ovf, m_perr, m_ferr;
  int         m_errs;

  ps2_rx_io dut (
    .clk          (clk),
    .rst          (rst),
    .IO_DataAddr  (IO_DataAddr),
    .PROC_DataOut (PROC_DataOut),
    .bwe          (bwe),
    .IO_DataOut   (IO_DataOut),
    .IO_EnableN   (IO_EnableN),
    .PS2_CLK      (PS2_CLK),
    .PS2_DAT      (PS2_DAT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_data();
    if (m_q.size() == 0) return 32'h0;
    return {23'b0, 1'b1, m_q[0]};
  endfunction

  function automatic logic [31:0] exp_stat();
    logic [7:0] ec;
    logic [6:0] cn;
    ec = 8'(m_errs);
    cn = 7'(m_q.size());
    return {8'b0, ec, 5'b0, m_ovf, m_perr, m_ferr,
            m_q.size() == DEPTH, cn};
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_ovf = 0; m_perr = 0; m_ferr = 0; m_errs = 0;
  endfunction

  function automatic void model_pop();
    if (m_q.size() > 0) void'(m_q.pop_front());
  endfunction

  function automatic void model_err();
    if (m_errs < 255) m_errs++;
  endfunction

  task automatic bus_read(input logic [31:0] a, input string tag);
    logic [31:0] e;
    logic        en;
    @(posedge clk); #1;
    IO_DataAddr = a;
    bwe = 4'h0;
    if (a == BASE) e = exp_data();
    else if (a == STAT) e = exp_stat();
    else e = 32'h0;
    en = !(a == BASE || a == STAT);
    @(posedge clk); #1;
    chk(tag, IO_DataOut, e);
    chk({tag, "_en"}, {31'b0, IO_EnableN}, {31'b0, en});
    IO_DataAddr = 32'h0;
  endtask

  task automatic bus_write(input logic [31:0] a);
    @(posedge clk); #1;
    IO_DataAddr = a;
    bwe = 4'(1 << $urandom_range(0, 3));
    PROC_DataOut = $urandom;
    @(posedge clk); #1;
    bwe = 4'h0;
    IO_DataAddr = 32'h0;
    if (a == BASE) model_pop();
    if (a == STAT) begin
      m_ovf = 0; m_perr = 0; m_ferr = 0; m_errs = 0;
    end
  endtask

  task automatic ps2_bit(input logic b, input bit pop_here);
    PS2_DAT = b;
    repeat (H) @(posedge clk);
    #1 PS2_CLK = 1'b0;
    if (pop_here) begin
      repeat (2) @(posedge clk);
      #1;
      IO_DataAddr = BASE;
      bwe = 4'hF;
      @(posedge clk); #1;
      bwe = 4'h0;
      IO_DataAddr = 32'h0;
      repeat (H - 3) @(posedge clk);
    end else begin
      repeat (H) @(posedge clk);
    end
    #1 PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badpar,
                            input bit badstop, input bit pop_stop);
    logic p;
    p = (~^b) ^ badpar;
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit(p, 0);
    ps2_bit(!badstop, pop_stop);
    PS2_DAT = 1'b1;
    repeat (2 * H) @(posedge clk);
    if (pop_stop) model_pop();
    if (!badpar && !badstop) begin
      if (m_q.size() < DEPTH) m_q.push_back(b);
      else m_ovf = 1;
    end else begin
      if (badpar) m_perr = 1;
      if (badstop) m_ferr = 1;
      model_err();
    end
  endtask

  task automatic partial_frame(input int nbits);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom), 0);
    PS2_DAT = 1'b1;
  endtask

  task automatic drain();
    while (m_q.size() > 0) bus_write(BASE);
    bus_write(STAT);
  endtask

  initial begin
    rst = 1'b1;
    IO_DataAddr = 32'h0;
    PROC_DataOut = 32'h0;
    bwe = 4'h0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_dout", IO_DataOut, 32'h0);
    chk("rst_en", {31'b0, IO_EnableN}, 32'h1);
    bus_read(STAT, "rst_stat");
    bus_read(BASE, "rst_data");

    send_frame(8'h1C, 0, 0, 0);
    chk("x1c_model", exp_data(), 32'h0000_011C);
    bus_read(BASE, "x1c_data");
    bus_write(BASE);
    bus_read(BASE, "x1c_pop");

    send_frame(8'h5A, 1, 0, 0);
    bus_read(STAT, "perr_stat");
    bus_read(BASE, "perr_data");
    bus_write(STAT);
    bus_read(STAT, "perr_clr");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
    bus_read(STAT, "ovf_stat");
    for (int i = 0; i < 8; i++) begin
      bus_read(BASE, "ovf_data");
      bus_write(BASE);
    end
    bus_read(BASE, "ovf_empty");
    bus_write(STAT);

    partial_frame(4);
    repeat (50100) @(posedge clk);
    m_ferr = 1;
    bus_read(STAT, "tmo_stat");
    send_frame(8'h33, 0, 0, 0);
    bus_read(STAT, "tmo_stat2");
    bus_read(BASE, "tmo_data");
    drain();

    for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 0, 0, 0);
    send_frame(8'hAA, 0, 0, 1);
    bus_read(STAT, "fpop_stat");
    for (int i = 0; i < DEPTH - 1; i++) bus_write(BASE);
    bus_read(BASE, "fpop_last");
    drain();

    for (int it = 0; it < 30; it++) begin
      int op;
      int r;
      op = $urandom_range(0, 5);
      if (op <= 2) begin
        r = $urandom_range(0, 7);
        send_frame(8'($urandom), r == 0, r == 1, 0);
      end else if (op == 3) begin
        bus_write(BASE);
      end else if (op == 4) begin
        bus_read(BASE, "rnd_data");
      end else begin
        if ($urandom_range(0, 3) == 0) bus_write(STAT);
        bus_read(STAT, "rnd_stat");
      end
    end
    bus_read(STAT, "rnd_stat_end");
    bus_read(BASE, "rnd_data_end");

    partial_frame(3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    model_reset();
    chk("mrst_dout", IO_DataOut, 32'h0);
    chk("mrst_en", {31'b0, IO_EnableN}, 32'h1);
    bus_read(STAT, "mrst_stat");
    send_frame(8'h77, 0, 0, 0);
    bus_read(BASE, "mrst_data");
    chk("mrst_model", exp_data(), 32'h0000_0177);
    bus_read(BASE + 32'd8, "miss");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
